// File: rtl/seq_multiplier_if.sv
// Operand/handshake bundle for seq_multiplier: request side (master) and multiplier side (slave).
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [0:WIDTH-1]     a;
    logic [0:WIDTH-1]     b;
    logic                 busy;
    logic                 done;
    logic [0:2*WIDTH-1]   result;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per RUN cycle; signed mode
// works on magnitudes and negates the product in a final SIGN cycle.
module seq_multiplier #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input logic            clk,
    input logic            reset,
    seq_multiplier_if.slave bus
);
    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned AW = 2 * WIDTH + STEP;
    localparam int unsigned HW = WIDTH + STEP;

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_in, b_in, mag_a;
    logic [AW-1:0]      acc, acc_next;
    logic [HW-1:0]      sum;
    logic [CW-1:0]      count;
    logic               neg;
    logic [2*WIDTH-1:0] result_q;
    logic               load, last, busy, done;

    // Magnitude fits in WIDTH unsigned bits even for the most-negative input.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign a_in       = bus.a;
    assign b_in       = bus.b;
    assign last       = (count == CW'(N - 1));
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;

    // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
    assign sum      = acc[AW-1:WIDTH] + HW'(mag_a) * HW'(acc[STEP-1:0]);
    assign acc_next = {sum, acc[WIDTH-1:0]} >> STEP;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = SIGN;
            end
            SIGN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            mag_a    <= '0;
            neg      <= 1'b0;
            count    <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                mag_a <= mag(a_in, bus.is_signed);
                acc   <= AW'(mag(b_in, bus.is_signed));
                neg   <= bus.is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                count <= '0;
            end else if (state == RUN) begin
                acc   <= acc_next;
                count <= count + CW'(1);
            end
            if (state == SIGN)
                result_q <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        end
    end
endmodule
